// File: rtl/spell_dbg_pkg.sv
// Shared types for the serial debug port.
//   state_e : debug-port FSM states
//   op_e    : pending operation type (write into / read from CPU register)
package spell_dbg_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT_WAIT,
        S_WR,
        S_RD,
        S_CAP,
        S_DONE
    } state_e;

    typedef enum logic {
        OP_LOAD,
        OP_DUMP
    } op_e;

endpackage

// File: rtl/spell_edge_det.sv
// Rising-edge detector for a bundle of level request lines.
//   i_sig  : level inputs, sampled every cycle
//   o_rise : high for the cycle where i_sig is 1 and was 0 the cycle before
module spell_edge_det #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_sig,
    output logic [W-1:0] o_rise
);

    logic [W-1:0] prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev_q <= '0;
        else     prev_q <= i_sig;
    end

    assign o_rise = i_sig & ~prev_q;

endmodule

// File: rtl/spell_dbg_port.sv
// Serial debug port: a shift chain that can be written into, or filled from,
// one of NUM_REGS CPU registers while the CPU is held halted.
//   clk/rst                      : clock, async active-high reset
//   i_shift_en/i_shift_in        : serial load of the chain (IDLE only), MSB first
//   o_shift_out                  : chain MSB
//   i_load/i_dump/i_reg_sel      : level requests, acted on at their rising edge
//   o_halt_req/i_halted          : CPU halt handshake
//   o_reg_addr/o_reg_we/
//   o_reg_wdata/i_reg_rdata      : CPU register-file access
//   o_busy/o_done/o_err          : status (o_err is sticky until next accepted request)
module spell_dbg_port
    import spell_dbg_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int NUM_REGS     = 4,
    parameter int HALT_TIMEOUT = 255,
    localparam int SEL_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_shift_en,
    input  logic              i_shift_in,
    output logic              o_shift_out,
    input  logic              i_load,
    input  logic              i_dump,
    input  logic [SEL_W-1:0]  i_reg_sel,
    output logic              o_halt_req,
    input  logic              i_halted,
    output logic [SEL_W-1:0]  o_reg_addr,
    output logic              o_reg_we,
    output logic [DATA_W-1:0] o_reg_wdata,
    input  logic [DATA_W-1:0] i_reg_rdata,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    localparam int CNT_W = $clog2(HALT_TIMEOUT + 1);

    state_e             state_q;
    op_e                op_q;
    logic [SEL_W-1:0]   addr_q;
    logic [DATA_W-1:0]  sr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               halt_q, we_q, done_q, err_q;
    logic [1:0]         rise;
    logic               ld_rise, dp_rise, sel_ok;

    spell_edge_det #(.W(2)) u_edge (
        .clk    (clk),
        .rst    (rst),
        .i_sig  ({i_dump, i_load}),
        .o_rise (rise)
    );
    assign ld_rise = rise[0];
    assign dp_rise = rise[1];

    // Table of legal indices so a non-power-of-two NUM_REGS rejects the holes.
    logic [(1<<SEL_W)-1:0] sel_ok_vec;
    for (genvar g = 0; g < (1 << SEL_W); g++) begin : g_sel_ok
        assign sel_ok_vec[g] = (g < NUM_REGS);
    end
    assign sel_ok = sel_ok_vec[i_reg_sel];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_LOAD;
            addr_q  <= '0;
            sr_q    <= '0;
            cnt_q   <= '0;
            halt_q  <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_shift_en) sr_q <= {sr_q[DATA_W-2:0], i_shift_in};
                    if (ld_rise || dp_rise) begin
                        if (!sel_ok) begin
                            err_q <= 1'b1;
                        end else begin
                            // Load wins a tie; the tie itself is reported.
                            addr_q  <= i_reg_sel;
                            op_q    <= ld_rise ? OP_LOAD : OP_DUMP;
                            err_q   <= ld_rise && dp_rise;
                            halt_q  <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= S_HALT_WAIT;
                        end
                    end
                end
                S_HALT_WAIT: begin
                    if (i_halted) begin
                        // Write strobe is registered so it lines up with the WR state.
                        we_q    <= (op_q == OP_LOAD);
                        state_q <= (op_q == OP_LOAD) ? S_WR : S_RD;
                    end else if (cnt_q == CNT_W'(HALT_TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        halt_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_WR: begin
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_RD: state_q <= S_CAP;
                S_CAP: begin
                    sr_q    <= i_reg_rdata;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    halt_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
            // Requests arriving mid-transfer are dropped but flagged.
            if (state_q != S_IDLE && (ld_rise || dp_rise)) err_q <= 1'b1;
        end
    end

    assign o_shift_out = sr_q[DATA_W-1];
    assign o_halt_req  = halt_q;
    assign o_reg_addr  = addr_q;
    assign o_reg_we    = we_q;
    assign o_reg_wdata = sr_q;
    assign o_busy      = (state_q != S_IDLE);
    assign o_done      = done_q;
    assign o_err       = err_q;

endmodule
